// File: rtl/posit_round_pack.sv
// Posit rounding and packing engine: turns a decoded (sign, regime, exponent, fraction)
// result into an N-bit posit with round-to-nearest-even, over a fixed four-stage sequence.
module posit_round_pack #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int MW = 64,
  parameter int KW = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sign_in,
  input  logic [KW-1:0]                k_in,
  input  logic [((ES > 0) ? ES : 1)-1:0] exp_in,
  input  logic [MW-1:0]                frac_in,
  input  logic                         zero_in,
  input  logic                         nar_in,
  output logic [N-1:0]                 posit_out,
  output logic                         done,
  output logic                         busy,
  output logic                         inexact
);

  localparam int EW = (ES > 0) ? ES : 1;
  localparam int TW = ES + MW;     // exponent + fraction tail length
  localparam int SW = N + 1 + TW;  // terminator + tail + room for the regime run

  typedef enum logic [2:0] {IDLE, BUILD, ROUND, PACK, DONE} state_e;

  typedef struct packed {
    logic          sign;
    logic [KW-1:0] k;
    logic [EW-1:0] exp;
    logic [MW-1:0] frac;
    logic          zero;
    logic          nar;
  } op_t;

  state_e state_q, state_d;
  op_t    op_q, op_d;

  // BUILD stage results
  logic [N-2:0] kept_q, kept_d;
  logic         guard_q, guard_d, sticky_q, sticky_d;
  logic         sat_max_q, sat_max_d, sat_min_q, sat_min_d;
  // ROUND stage results
  logic [N-2:0] rnd_body_q, rnd_body_d;
  logic         rnd_inexact_q, rnd_inexact_d;
  // PACK stage results
  logic [N-1:0] pack_q, pack_d;
  logic         pack_inexact_q, pack_inexact_d;
  // Visible outputs
  logic [N-1:0] posit_out_q, posit_out_d;
  logic         inexact_q, inexact_d, done_q, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUILD;
      BUILD:   state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    posit_out = posit_out_q;
    inexact   = inexact_q;
  end

  // Operand capture and BUILD: regime run, terminator, then exp/frac, left-aligned.
  logic            neg_k;
  logic [KW-1:0]   run_len;
  logic [EW+MW-1:0] ef;
  logic [SW-1:0]   str_base, fill_mask, str;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op_d = op_q;
    if (state_q == IDLE && start) begin
      op_d.sign = sign_in;
      op_d.k    = k_in;
      op_d.exp  = exp_in;
      op_d.frac = frac_in;
      op_d.zero = zero_in;
      op_d.nar  = nar_in;
    end

    neg_k     = op_q.k[KW-1];
    run_len   = neg_k ? (~op_q.k + KW'(1)) : (op_q.k + KW'(1));
    ef        = {op_q.exp, op_q.frac};
    str_base  = {neg_k, ef[TW-1:0], {N{1'b0}}};
    fill_mask = neg_k ? '0 : ~({SW{1'b1}} >> run_len);
    str       = (str_base >> run_len) | fill_mask;

    kept_d    = str[SW-1 -: N-1];
    guard_d   = str[SW-N];
    sticky_d  = |str[SW-N-1:0];
    sat_max_d = int'($signed(op_q.k)) >= N - 2;
    sat_min_d = int'($signed(op_q.k)) <= -(N - 1);
  end

  // ROUND: nearest-even increment, then clamp into [minpos, maxpos].
  logic         inc;
  logic [N-1:0] sum;

  always_comb begin
    inc = guard_q & (kept_q[0] | sticky_q);
    sum = {1'b0, kept_q} + N'(inc);
    if (sat_max_q || sum[N-1])          rnd_body_d = '1;
    else if (sat_min_q || sum[N-2:0] == '0) rnd_body_d = (N-1)'(1);
    else                                rnd_body_d = sum[N-2:0];
    rnd_inexact_d = sat_max_q | sat_min_q | guard_q | sticky_q;
  end

  // PACK: apply sign by two's complement; specials override everything.
  logic [N-1:0] mag;

  always_comb begin
    mag            = {1'b0, rnd_body_q};
    pack_inexact_d = rnd_inexact_q;
    if (op_q.nar) begin
      pack_d         = {1'b1, {(N-1){1'b0}}};
      pack_inexact_d = 1'b0;
    end else if (op_q.zero) begin
      pack_d         = '0;
      pack_inexact_d = 1'b0;
    end else if (op_q.sign) begin
      pack_d         = ~mag + N'(1);
    end else begin
      pack_d         = mag;
    end
  end

  // Outputs only move on the DONE->IDLE edge so they hold between results.
  always_comb begin
    done_d      = (state_q == DONE);
    posit_out_d = done_d ? pack_q : posit_out_q;
    inexact_d   = done_d ? pack_inexact_q : inexact_q;
  end

  // NOTE: datapath pipeline registers are not reset; they are always rewritten before being observed.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    if (state_q == BUILD) begin
      kept_q    <= kept_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      sat_max_q <= sat_max_d;
      sat_min_q <= sat_min_d;
    end
    if (state_q == ROUND) begin
      rnd_body_q    <= rnd_body_d;
      rnd_inexact_q <= rnd_inexact_d;
    end
    if (state_q == PACK) begin
      pack_q         <= pack_d;
      pack_inexact_q <= pack_inexact_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posit_out_q <= '0;
      inexact_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      posit_out_q <= posit_out_d;
      inexact_q   <= inexact_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_posit_round_pack.sv
// Directed bench for posit_round_pack (N=32, ES=2, MW=64) with hand-computed expectations.
module tb_posit_round_pack;

  logic        clk = 1'b0;
  logic        rst, start, sign_in, zero_in, nar_in;
  logic [5:0]  k_in;
  logic [1:0]  exp_in;
  logic [63:0] frac_in;
  logic [31:0] posit_out;
  logic        done, busy, inexact;

  int n_checks = 0;
  int n_fail   = 0;

  posit_round_pack #(.N(32), .ES(2), .MW(64), .KW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sign_in(sign_in), .k_in(k_in),
    .exp_in(exp_in), .frac_in(frac_in), .zero_in(zero_in), .nar_in(nar_in),
    .posit_out(posit_out), .done(done), .busy(busy), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input bit s, input int k, input logic [1:0] e,
                         input logic [63:0] f, input bit z, input bit n);
    sign_in = s; k_in = 6'(k); exp_in = e; frac_in = f; zero_in = z; nar_in = n;
  endtask

  // Edges after the accepting edge until done is seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic do_vec(input string tag, input bit s, input int k, input logic [1:0] e,
                        input logic [63:0] f, input bit z, input bit n,
                        input logic [31:0] exp_p, input bit exp_i, input bit chk_i);
    int lat;
    set_ops(s, k, e, f, z, n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat + 1), 64'd4 + 64'd1);
    check({tag, " posit"}, 64'(posit_out), 64'(exp_p));
    if (chk_i) check({tag, " inexact"}, 64'(inexact), 64'(exp_i));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, cnt, seen;
    rst = 1'b1; start = 1'b1;
    set_ops(1'b0, 0, 2'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset posit", 64'(posit_out), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset inexact", 64'(inexact), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle after reset", 64'(busy), 64'd0);

    do_vec("one",        0,   0, 2'd0, 64'h0,                  0, 0, 32'h40000000, 0, 1);
    do_vec("minus one",  1,   0, 2'd0, 64'h0,                  0, 0, 32'hC0000000, 0, 1);
    do_vec("tie even",   0,   0, 2'd0, 64'h0000_0010_0000_0000, 0, 0, 32'h40000000, 1, 1);
    do_vec("tie odd",    0,   0, 2'd0, 64'h0000_0030_0000_0000, 0, 0, 32'h40000002, 1, 1);
    do_vec("above half", 0,   0, 2'd0, 64'h0000_0018_0000_0000, 0, 0, 32'h40000001, 1, 1);
    do_vec("sticky only",0,   0, 2'd0, 64'h1,                  0, 0, 32'h40000000, 1, 1);
    do_vec("neg tie odd",1,   0, 2'd0, 64'h0000_0030_0000_0000, 0, 0, 32'hBFFFFFFE, 1, 1);
    do_vec("k -1",       0,  -1, 2'd1, 64'h8000_0000_0000_0000, 0, 0, 32'h2C000000, 0, 1);
    do_vec("k 2",        0,   2, 2'd2, 64'h0,                  0, 0, 32'h74000000, 0, 1);
    do_vec("k 30 sat",   0,  30, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h7FFFFFFF, 1, 0);
    do_vec("k 29 carry", 0,  29, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h7FFFFFFF, 1, 1);
    do_vec("k -31 min",  0, -31, 2'd0, 64'h0,                  0, 0, 32'h00000001, 0, 0);
    do_vec("neg minpos", 1, -31, 2'd0, 64'h0,                  0, 0, 32'hFFFFFFFF, 0, 0);
    do_vec("k -30 up",   0, -30, 2'd3, 64'h0,                  0, 0, 32'h00000002, 1, 1);
    do_vec("nar",        0,   5, 2'd1, 64'h1,                  1, 1, 32'h80000000, 0, 1);
    do_vec("zero",       1,   5, 2'd1, 64'h1,                  1, 0, 32'h00000000, 0, 1);

    // start while busy and operand changes after acceptance must not disturb the result
    set_ops(0, 0, 2'd0, 64'h0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    set_ops(1, 7, 2'd3, 64'hDEAD_BEEF_0000_0001, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("busy start latency", 64'(lat), 64'd3);
    check("busy start posit", 64'(posit_out), 64'h40000000);

    // back-to-back: start on the done cycle
    set_ops(0, 2, 2'd2, 64'h0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b spacing", 64'(lat + 1), 64'd5);
    check("b2b posit", 64'(posit_out), 64'h74000000);

    // known nonzero result, then abort an operation with rst+start during ROUND
    @(posedge clk); #1;
    do_vec("pre abort",  0,   0, 2'd0, 64'h0000_0030_0000_0000, 0, 0, 32'h40000002, 1, 1);
    set_ops(1, 0, 2'd0, 64'h0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort posit", 64'(posit_out), 64'd0);
    check("abort inexact", 64'(inexact), 64'd0);
    seen = 0;
    for (cnt = 0; cnt < 8; cnt++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);
    do_vec("after abort", 1,  0, 2'd0, 64'h0,                  0, 0, 32'hC0000000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_round_pack.md
POSIT_ROUND_PACK -- requirements
Module: posit_round_pack

Interface
REQ-001 SHALL have parameter N, default 32: output posit width, legal 8..32.
REQ-002 SHALL have parameter ES, default 2: exponent field width, legal 0..3.
REQ-003 SHALL have parameter MW, default 64: fraction input width, legal at least N.
REQ-004 SHALL have parameter KW, default 6: signed regime input width, at least clog2(N)+1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request; operands sampled on the same edge.
REQ-008 sign_in  in  1  result sign, 1 = negative.
REQ-009 k_in  in  KW  signed regime value.
REQ-010 exp_in  in  ES  exponent field; ignored when ES=0.
REQ-011 frac_in  in  MW  fraction bits after the hidden bit, MSB-aligned.
REQ-012 zero_in  in  1  result is exact zero.
REQ-013 nar_in  in  1  result is NaR; has priority over zero_in.
REQ-014 posit_out  out  N  packed, rounded posit.
REQ-015 done  out  1  one-cycle pulse; posit_out valid.
REQ-016 busy  out  1  high from the cycle after accepted start until done.
REQ-017 inexact  out  1  any discarded bit nonzero; valid with done.

Function
REQ-018 FSM SHALL have states IDLE, BUILD, ROUND, PACK, DONE.
REQ-019 IDLE->BUILD on start; BUILD->ROUND->PACK->DONE unconditionally; DONE->IDLE unconditionally.
REQ-020 start SHALL be accepted only in IDLE; start in any other state is ignored with no side effects.
REQ-021 Accepted operands SHALL be registered at acceptance; later input changes SHALL NOT affect the result.
REQ-022 done SHALL assert exactly 4 cycles after the accepting edge, for exactly 1 cycle.
REQ-023 Back-to-back start SHALL be accepted on the cycle done is high (FSM back in IDLE next edge), giving 5-cycle throughput.
REQ-024 BUILD: regime for k>=0 SHALL be (k+1) ones then a zero; for k<0, -k zeros then a one.
REQ-025 BUILD: body string SHALL be regime, then exp_in, then frac_in, truncated at the regime terminator where the regime fills N-1 bits.
REQ-026 ROUND: the top N-1 body bits SHALL be kept; guard = next bit; sticky = OR of all remaining bits.
REQ-027 ROUND: increment SHALL occur when guard AND (kept LSB OR sticky), i.e. round-to-nearest-even.
REQ-028 ROUND: inexact SHALL equal guard OR sticky.
REQ-029 Saturation: k_in >= N-2, or increment overflowing an all-ones body, SHALL give body maxpos (all ones).
REQ-030 Saturation: k_in <= -(N-1), or an all-zero body for a nonzero input, SHALL give minpos (body = 1).
REQ-031 A nonzero input SHALL never round to zero or NaR.
REQ-032 PACK: posit_out = {0, body} if sign_in=0, else its two's complement modulo 2^N.
REQ-033 nar_in SHALL give 1 followed by N-1 zeros with inexact=0; zero_in (without nar_in) SHALL give all zeros with inexact=0.
REQ-034 posit_out and inexact SHALL hold from done until the next done; they SHALL NOT change mid-operation.

Reset
REQ-035 rst SHALL force IDLE, posit_out=0, done=0, busy=0, inexact=0 on the next edge.
REQ-036 rst SHALL take priority over start, including start on the same edge.
REQ-037 rst during BUILD/ROUND/PACK/DONE SHALL abort the operation with no done pulse.

Verification (N=32, ES=2, MW=64)
REQ-038 sign=0, k=0, exp=0, frac=0 -> 0x40000000, inexact=0, done 4 cycles after start; sign=1 -> 0xC0000000.
REQ-039 k=0, exp=0, frac=0x0000_0010_0000_0000 (tie, even LSB) -> 0x40000000, inexact=1; frac=0x0000_0030_0000_0000 (tie, odd LSB) -> 0x40000002, inexact=1.
REQ-040 k=30 or k=29 with frac all ones -> 0x7FFFFFFF; k=-31 -> 0x00000001; sign=1 with k=-31 -> 0xFFFFFFFF.
REQ-041 nar_in=1 with zero_in=1 -> 0x80000000; zero_in=1 alone -> 0x00000000; inexact=0 for both.
REQ-042 start pulsed while busy -> ignored, first result unchanged; start on the done cycle -> second done 5 cycles after the first.
REQ-043 rst asserted in ROUND together with start -> no done, outputs 0, FSM in IDLE; next start completes normally.
